// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: consumer-side partner of the D->E pipeline register.
// Shadows the E-stage write information into M and W, then derives the
// stall / CLR_E request and the D- and E-stage forwarding selects.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN;
// without it stall_cnt is a constant zero and no counter flops exist.
module hazard_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int T_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read1addr_D,
  input  logic [ADDR_W-1:0] read2addr_D,
  input  logic [T_W-1:0]    tuse_rs_D,
  input  logic [T_W-1:0]    tuse_rt_D,
  input  logic              rfwe_E,
  input  logic [ADDR_W-1:0] writeaddr_E,
  input  logic [T_W-1:0]    tnew_E,
  input  logic [ADDR_W-1:0] read1addr_E,
  input  logic [ADDR_W-1:0] read2addr_E,
  output logic              stall,
  output logic              CLR_E,
  output logic [1:0]        fwd_rs_D,
  output logic [1:0]        fwd_rt_D,
  output logic [1:0]        fwd_rs_E,
  output logic [1:0]        fwd_rt_E,
  output logic [31:0]       stall_cnt
);

  logic [ADDR_W-1:0] r_wa_M, r_wa_W;
  logic [T_W-1:0]    r_tnew_M, r_tnew_W;
  logic [ADDR_W-1:0] w_wa_E;
  logic              w_hazard_rs, w_hazard_rt;

  // Address 0 doubles as "no writer", so a non-writing E never matches.
  assign w_wa_E = rfwe_E ? writeaddr_E : '0;

  // Newest matching stage decides whether the operand must wait.
  function automatic logic hazard(
    input logic [ADDR_W-1:0] a,
    input logic [T_W-1:0]    tuse,
    input logic [ADDR_W-1:0] wa_e, wa_m, wa_w,
    input logic [T_W-1:0]    t_e, t_m, t_w
  );
    if (a == '0)   return 1'b0;
    if (wa_e == a) return t_e > tuse;
    if (wa_m == a) return t_m > tuse;
    if (wa_w == a) return t_w > tuse;
    return 1'b0;
  endfunction

  // Newest matching stage is the only candidate; it forwards only when ready.
  function automatic logic [1:0] sel_d(
    input logic [ADDR_W-1:0] a,
    input logic [ADDR_W-1:0] wa_e, wa_m, wa_w,
    input logic [T_W-1:0]    t_e, t_m, t_w
  );
    if (a == '0)   return 2'd0;
    if (wa_e == a) return (t_e == '0) ? 2'd1 : 2'd0;
    if (wa_m == a) return (t_m == '0) ? 2'd2 : 2'd0;
    if (wa_w == a) return (t_w == '0) ? 2'd3 : 2'd0;
    return 2'd0;
  endfunction

  // E-stage operands: an unready M match shadows W and yields the latched value.
  function automatic logic [1:0] sel_e(
    input logic [ADDR_W-1:0] a,
    input logic [ADDR_W-1:0] wa_m, wa_w,
    input logic [T_W-1:0]    t_m
  );
    if (a == '0)   return 2'd0;
    if (wa_m == a) return (t_m == '0) ? 2'd2 : 2'd0;
    if (wa_w == a) return 2'd3;
    return 2'd0;
  endfunction

  assign w_hazard_rs = hazard(read1addr_D, tuse_rs_D, w_wa_E, r_wa_M, r_wa_W,
                              tnew_E, r_tnew_M, r_tnew_W);
  assign w_hazard_rt = hazard(read2addr_D, tuse_rt_D, w_wa_E, r_wa_M, r_wa_W,
                              tnew_E, r_tnew_M, r_tnew_W);

  assign stall = w_hazard_rs | w_hazard_rt;
  assign CLR_E = stall;

  assign fwd_rs_D = sel_d(read1addr_D, w_wa_E, r_wa_M, r_wa_W, tnew_E, r_tnew_M, r_tnew_W);
  assign fwd_rt_D = sel_d(read2addr_D, w_wa_E, r_wa_M, r_wa_W, tnew_E, r_tnew_M, r_tnew_W);
  assign fwd_rs_E = sel_e(read1addr_E, r_wa_M, r_wa_W, r_tnew_M);
  assign fwd_rt_E = sel_e(read2addr_E, r_wa_M, r_wa_W, r_tnew_M);

  // Shift E write info into M and W, counting Tnew down and saturating at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wa_M   <= '0;
      r_tnew_M <= '0;
      r_wa_W   <= '0;
      r_tnew_W <= '0;
    end else begin
      r_wa_M   <= w_wa_E;
      r_tnew_M <= (tnew_E == '0) ? '0 : tnew_E - 1'b1;
      r_wa_W   <= r_wa_M;
      r_tnew_W <= (r_tnew_M == '0) ? '0 : r_tnew_M - 1'b1;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Count stalled cycles; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) r_stall_cnt <= '0;
    else if (stall) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] read1addr_D, read2addr_D, writeaddr_E, read1addr_E, read2addr_E;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_E;
  logic       rfwe_E;
  logic       stall, CLR_E;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic [31:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  hazard_scoreboard #(.ADDR_W(5), .T_W(2)) dut (
    .clk(clk), .reset(reset),
    .read1addr_D(read1addr_D), .read2addr_D(read2addr_D),
    .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .rfwe_E(rfwe_E), .writeaddr_E(writeaddr_E), .tnew_E(tnew_E),
    .read1addr_E(read1addr_E), .read2addr_E(read2addr_E),
    .stall(stall), .CLR_E(CLR_E),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    read1addr_D = '0; read2addr_D = '0; tuse_rs_D = '0; tuse_rt_D = '0;
    rfwe_E = 1'b0; writeaddr_E = '0; tnew_E = '0;
    read1addr_E = '0; read2addr_E = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (stall !== 1'b0 || CLR_E !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall: got stall=%b clr=%b expected 0 0", stall, CLR_E);
    end
    checks++;
    if ({fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E} !== 8'h00) begin
      failures++;
      $display("FAIL reset_fwd: got %h expected 00", {fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E});
    end
    checks++;
    if (stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_cnt: got %0d expected 0", stall_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    rfwe_E = 1'b1; writeaddr_E = 5'd8; tnew_E = 2'd2;
    read1addr_D = 5'd8; tuse_rs_D = 2'd0;
    #1;
    checks++;
    if (stall !== 1'b1 || CLR_E !== 1'b1) begin
      failures++;
      $display("FAIL load_use_e: got stall=%b clr=%b expected 1 1", stall, CLR_E);
    end
    tick();
    rfwe_E = 1'b0; writeaddr_E = '0; tnew_E = '0;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL load_use_m: got stall=%b expected 1", stall);
    end
    tick();
    read1addr_E = 5'd8;
    #1;
    checks++;
    if (stall !== 1'b0 || fwd_rs_D !== 2'd3) begin
      failures++;
      $display("FAIL load_use_w: got stall=%b fwd_rs_D=%0d expected 0 3", stall, fwd_rs_D);
    end
    checks++;
    if (fwd_rs_E !== 2'd3) begin
      failures++;
      $display("FAIL load_use_w_e: got fwd_rs_E=%0d expected 3", fwd_rs_E);
    end
  endtask

  task automatic test_alu_forward();
    do_reset();
    rfwe_E = 1'b1; writeaddr_E = 5'd9; tnew_E = 2'd1;
    read2addr_D = 5'd9; tuse_rt_D = 2'd1;
    #1;
    checks++;
    if (stall !== 1'b0 || fwd_rt_D !== 2'd0) begin
      failures++;
      $display("FAIL alu_d: got stall=%b fwd_rt_D=%0d expected 0 0", stall, fwd_rt_D);
    end
    tick();
    rfwe_E = 1'b0; writeaddr_E = '0; tnew_E = '0; read2addr_E = 5'd9;
    #1;
    checks++;
    if (fwd_rt_E !== 2'd2 || fwd_rt_D !== 2'd2) begin
      failures++;
      $display("FAIL alu_m: got fwd_rt_E=%0d fwd_rt_D=%0d expected 2 2", fwd_rt_E, fwd_rt_D);
    end
    tick();
    #1;
    checks++;
    if (fwd_rt_E !== 2'd3 || fwd_rs_E !== 2'd0) begin
      failures++;
      $display("FAIL alu_w: got fwd_rt_E=%0d fwd_rs_E=%0d expected 3 0", fwd_rt_E, fwd_rs_E);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    rfwe_E = 1'b1; writeaddr_E = 5'd0; tnew_E = 2'd2;
    read1addr_D = 5'd0; read2addr_D = 5'd0;
    #1;
    checks++;
    if (stall !== 1'b0 || fwd_rs_D !== 2'd0 || fwd_rt_D !== 2'd0) begin
      failures++;
      $display("FAIL zero_d: got stall=%b rs=%0d rt=%0d expected 0 0 0", stall, fwd_rs_D, fwd_rt_D);
    end
    tick();
    tick();
    #1;
    checks++;
    if (stall !== 1'b0 || fwd_rs_E !== 2'd0 || fwd_rs_D !== 2'd0) begin
      failures++;
      $display("FAIL zero_mw: got stall=%b rs_E=%0d rs_D=%0d expected 0 0 0", stall, fwd_rs_E, fwd_rs_D);
    end
  endtask

  task automatic test_priority();
    do_reset();
    rfwe_E = 1'b1; writeaddr_E = 5'd5; tnew_E = 2'd0;
    tick();
    read1addr_D = 5'd5; read2addr_D = 5'd5;
    #1;
    checks++;
    if (fwd_rs_D !== 2'd1 || fwd_rt_D !== 2'd1) begin
      failures++;
      $display("FAIL prio_e_over_m: got rs=%0d rt=%0d expected 1 1", fwd_rs_D, fwd_rt_D);
    end
    // Build M: wa6 tnew1, W: wa6 tnew0 -> M must shadow W.
    writeaddr_E = 5'd6; tnew_E = 2'd1; read1addr_D = '0; read2addr_D = '0;
    tick();
    tnew_E = 2'd2;
    tick();
    rfwe_E = 1'b0; writeaddr_E = '0; tnew_E = '0;
    read1addr_D = 5'd6; tuse_rs_D = 2'd0; read1addr_E = 5'd6;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL prio_m_over_w_stall: got %b expected 1", stall);
    end
    checks++;
    if (fwd_rs_E !== 2'd0) begin
      failures++;
      $display("FAIL prio_m_over_w_fwd_e: got %0d expected 0", fwd_rs_E);
    end
  endtask

  task automatic test_dual_hazard();
    do_reset();
    rfwe_E = 1'b1; writeaddr_E = 5'd12; tnew_E = 2'd2;
    read1addr_D = 5'd12; read2addr_D = 5'd12; tuse_rs_D = 2'd1; tuse_rt_D = 2'd0;
    #1;
    checks++;
    if (stall !== 1'b1 || CLR_E !== 1'b1) begin
      failures++;
      $display("FAIL dual_stall: got stall=%b clr=%b expected 1 1", stall, CLR_E);
    end
    tuse_rs_D = 2'd2; tuse_rt_D = 2'd2;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL tuse_eq_tnew: got stall=%b expected 0", stall);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    rfwe_E = 1'b1; writeaddr_E = 5'd8; tnew_E = 2'd2;
    tick();
    rfwe_E = 1'b0; writeaddr_E = '0; tnew_E = '0;
    read1addr_D = 5'd8; tuse_rs_D = 2'd0;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL mid_stall_pre: got %b expected 1", stall);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL mid_stall_post: got stall=%b cnt=%0d expected 0 0", stall, stall_cnt);
    end
  endtask

  task automatic test_stall_cnt();
    logic [31:0] exp_cnt;
`ifdef HAZARD_STALL_CNT_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    do_reset();
    rfwe_E = 1'b1; writeaddr_E = 5'd8; tnew_E = 2'd2;
    read1addr_D = 5'd8; tuse_rs_D = 2'd0;
    tick();
    tick();
    tick();
    idle_inputs();
    #1;
    checks++;
    if (stall_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL stall_cnt_3: got %0d expected %0d", stall_cnt, exp_cnt);
    end
    tick();
    tick();
    tick();
    #1;
    checks++;
    if (stall_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL stall_cnt_hold: got %0d expected %0d", stall_cnt, exp_cnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_alu_forward();
    test_zero_reg();
    test_priority();
    test_dual_hazard();
    test_reset_mid_stall();
    test_stall_cnt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
